// File: rtl/fila_pkg.sv
// Shared widths, queue depth and driver state encoding for the queue initiator.
package fila_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int LEN_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENQ      = 3'd1,
        ST_ENQ_WAIT = 3'd2,
        ST_DEQ      = 3'd3,
        ST_DEQ_DATA = 3'd4,
        ST_DEQ_WAIT = 3'd5
    } fila_drv_state_t;

    // Anything at or above capacity counts as full, so a corrupt length never allows a push.
    function automatic logic len_is_full(input logic [LEN_W-1:0] len);
        return len >= LEN_W'(DEPTH);
    endfunction

endpackage

// File: rtl/fila_driver_btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stable-time debouncer, rising-edge pulse.
module btn_debounce #(
    parameter int DEB_CYCLES = 100
) (
    input  logic clk_10KHz,
    input  logic reset_n,
    input  logic btn_in,
    output logic btn_rise
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEB_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Counter reloads on every sample that agrees with the current level; the level only
    // flips once the counter has run down through DEB_CYCLES disagreeing samples in a row.
    always_ff @(posedge clk_10KHz or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            level    <= 1'b0;
            cnt      <= '0;
            btn_rise <= 1'b0;
        end else begin
            sync_q1  <= btn_in;
            sync_q2  <= sync_q1;
            btn_rise <= 1'b0;
            if (sync_q2 == level) begin
                cnt <= CNT_LOAD;
            end else if (cnt == '0) begin
                level    <= sync_q2;
                cnt      <= CNT_LOAD;
                btn_rise <= sync_q2;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fila_driver.sv
// Queue initiator: debounced buttons become single-cycle enqueue/dequeue commands,
// with occupancy tracking, dequeued-value capture and rejection of illegal requests.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | waiting for a button request; validates it against full/empty
// ST_ENQ      | q_enqueue_out high for this single cycle
// ST_ENQ_WAIT | queue length settles after the push
// ST_DEQ      | q_dequeue_out high for this single cycle
// ST_DEQ_DATA | queue head is valid; captured into disp_data_out
// ST_DEQ_WAIT | queue shifts and decrements its length
module fila_driver
    import fila_pkg::*;
#(
    parameter int DEB_CYCLES = 100
) (
    input  logic              clk_10KHz,
    input  logic              reset_n,
    input  logic              btn_enq_in,
    input  logic              btn_deq_in,
    input  logic [DATA_W-1:0] sw_data_in,
    input  logic [LEN_W-1:0]  q_len_in,
    input  logic [DATA_W-1:0] q_data_in,
    output logic [DATA_W-1:0] q_data_out,
    output logic              q_enqueue_out,
    output logic              q_dequeue_out,
    output logic [DATA_W-1:0] disp_data_out,
    output logic [LEN_W-1:0]  disp_len_out,
    output logic              deq_valid_out,
    output logic              full_out,
    output logic              empty_out,
    output logic              err_out
);

    fila_drv_state_t state;
    logic            enq_req;
    logic            deq_req;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enq (
        .clk_10KHz (clk_10KHz),
        .reset_n   (reset_n),
        .btn_in    (btn_enq_in),
        .btn_rise  (enq_req)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_deq (
        .clk_10KHz (clk_10KHz),
        .reset_n   (reset_n),
        .btn_in    (btn_deq_in),
        .btn_rise  (deq_req)
    );

    assign full_out  = len_is_full(q_len_in);
    assign empty_out = (q_len_in == '0);

    always_ff @(posedge clk_10KHz or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            q_data_out    <= '0;
            q_enqueue_out <= 1'b0;
            q_dequeue_out <= 1'b0;
            disp_data_out <= '0;
            disp_len_out  <= '0;
            deq_valid_out <= 1'b0;
            err_out       <= 1'b0;
        end else begin
            q_enqueue_out <= 1'b0;
            q_dequeue_out <= 1'b0;
            deq_valid_out <= 1'b0;
            err_out       <= 1'b0;
            disp_len_out  <= q_len_in;

            // Busy: any request outside IDLE is dropped, never queued for later.
            if (state != ST_IDLE && (enq_req || deq_req)) begin
                err_out <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (enq_req && deq_req) begin
                        err_out <= 1'b1;
                    end else if (enq_req) begin
                        if (full_out) begin
                            err_out <= 1'b1;
                        end else begin
                            state         <= ST_ENQ;
                            q_data_out    <= sw_data_in;
                            q_enqueue_out <= 1'b1;
                        end
                    end else if (deq_req) begin
                        if (empty_out) begin
                            err_out <= 1'b1;
                        end else begin
                            state         <= ST_DEQ;
                            q_dequeue_out <= 1'b1;
                        end
                    end
                end
                ST_ENQ:      state <= ST_ENQ_WAIT;
                ST_ENQ_WAIT: state <= ST_IDLE;
                ST_DEQ:      state <= ST_DEQ_DATA;
                ST_DEQ_DATA: begin
                    disp_data_out <= q_data_in;
                    deq_valid_out <= 1'b1;
                    state         <= ST_DEQ_WAIT;
                end
                ST_DEQ_WAIT: state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fila_driver.sv
// Directed bench for fila_driver with a behavioural 8-entry queue attached.
`timescale 1ns/1ps
module tb_fila_driver;

    logic       clk_10KHz = 1'b0;
    logic       reset_n;
    logic       btn_enq_in;
    logic       btn_deq_in;
    logic [7:0] sw_data_in;
    logic [7:0] q_len_in  = 8'd0;
    logic [7:0] q_data_in = 8'd0;
    logic [7:0] q_data_out;
    logic       q_enqueue_out;
    logic       q_dequeue_out;
    logic [7:0] disp_data_out;
    logic [7:0] disp_len_out;
    logic       deq_valid_out;
    logic       full_out;
    logic       empty_out;
    logic       err_out;

    always #50 clk_10KHz = ~clk_10KHz;

    fila_driver #(.DEB_CYCLES(4)) dut (
        .clk_10KHz     (clk_10KHz),
        .reset_n       (reset_n),
        .btn_enq_in    (btn_enq_in),
        .btn_deq_in    (btn_deq_in),
        .sw_data_in    (sw_data_in),
        .q_len_in      (q_len_in),
        .q_data_in     (q_data_in),
        .q_data_out    (q_data_out),
        .q_enqueue_out (q_enqueue_out),
        .q_dequeue_out (q_dequeue_out),
        .disp_data_out (disp_data_out),
        .disp_len_out  (disp_len_out),
        .deq_valid_out (deq_valid_out),
        .full_out      (full_out),
        .empty_out     (empty_out),
        .err_out       (err_out)
    );

    // Queue model: head data appears the cycle after the dequeue is sampled.
    logic [7:0] mem [0:7];
    always @(posedge clk_10KHz) begin
        if (q_enqueue_out && q_len_in < 8'd8) begin
            mem[q_len_in[2:0]] <= q_data_out;
            q_len_in           <= q_len_in + 8'd1;
        end else if (q_dequeue_out && q_len_in != 8'd0) begin
            q_data_in <= mem[0];
            for (int k = 0; k < 7; k++) mem[k] <= mem[k+1];
            q_len_in <= q_len_in - 8'd1;
        end
    end

    int         enq_seen = 0, deq_seen = 0, err_seen = 0, valid_seen = 0;
    int         overlap_viol = 0, consec_viol = 0;
    logic [7:0] enq_data_last = 8'd0, disp_last = 8'd0;
    logic       prev_enq = 1'b0, prev_deq = 1'b0;

    always @(negedge clk_10KHz) begin
        if (q_enqueue_out) begin
            enq_seen      <= enq_seen + 1;
            enq_data_last <= q_data_out;
        end
        if (q_dequeue_out) deq_seen <= deq_seen + 1;
        if (err_out) err_seen <= err_seen + 1;
        if (deq_valid_out) begin
            valid_seen <= valid_seen + 1;
            disp_last  <= disp_data_out;
        end
        if (q_enqueue_out && q_dequeue_out) overlap_viol <= overlap_viol + 1;
        if ((q_enqueue_out && prev_enq) || (q_dequeue_out && prev_deq)) consec_viol <= consec_viol + 1;
        prev_enq <= q_enqueue_out;
        prev_deq <= q_dequeue_out;
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       p_enq;
        logic       p_deq;
        logic [7:0] sw;
        int         x_enq;
        int         x_deq;
        int         x_err;
        logic [7:0] x_qdata;
        logic [7:0] x_disp;
        logic [7:0] x_len;
        logic       x_full;
        logic       x_empty;
    } op_t;

    op_t tbl [0:17];

    task automatic apply_op(input int id, input op_t r);
        int s_enq, s_deq, s_err, s_val;
        s_enq = enq_seen; s_deq = deq_seen; s_err = err_seen; s_val = valid_seen;
        @(negedge clk_10KHz);
        btn_enq_in = r.p_enq;
        btn_deq_in = r.p_deq;
        sw_data_in = r.sw;
        repeat (12) @(negedge clk_10KHz);
        btn_enq_in = 1'b0;
        btn_deq_in = 1'b0;
        repeat (12) @(negedge clk_10KHz);
        check($sformatf("op%0d_enq_cnt", id), enq_seen - s_enq, r.x_enq);
        check($sformatf("op%0d_deq_cnt", id), deq_seen - s_deq, r.x_deq);
        check($sformatf("op%0d_err_cnt", id), err_seen - s_err, r.x_err);
        check($sformatf("op%0d_valid_cnt", id), valid_seen - s_val, r.x_deq);
        if (r.x_enq != 0) check($sformatf("op%0d_q_data", id), int'(enq_data_last), int'(r.x_qdata));
        if (r.x_deq != 0) begin
            check($sformatf("op%0d_disp_pulse", id), int'(disp_last), int'(r.x_disp));
            check($sformatf("op%0d_disp_data", id), int'(disp_data_out), int'(r.x_disp));
        end
        check($sformatf("op%0d_disp_len", id), int'(disp_len_out), int'(r.x_len));
        check($sformatf("op%0d_full", id), int'(full_out), int'(r.x_full));
        check($sformatf("op%0d_empty", id), int'(empty_out), int'(r.x_empty));
    endtask

    initial begin
        int   s_enq, s_deq, s_err;
        logic found;
        op_t  rec;

        //          enq   deq   sw     enq deq err qdata  disp   len    full  empty
        tbl[0]  = '{1'b1, 1'b0, 8'hA5, 1, 0, 0, 8'hA5, 8'h00, 8'd1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'h00, 0, 1, 0, 8'h00, 8'hA5, 8'd0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 8'h11, 1, 0, 0, 8'h11, 8'h00, 8'd1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h22, 1, 0, 0, 8'h22, 8'h00, 8'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h00, 0, 1, 0, 8'h00, 8'h11, 8'd1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h00, 0, 1, 0, 8'h00, 8'h22, 8'd0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'd0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 8'h33, 0, 0, 1, 8'h00, 8'h00, 8'd0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++)
            tbl[8+i] = '{1'b1, 1'b0, 8'(i+1), 1, 0, 0, 8'(i+1), 8'h00, 8'(i+1), (i == 7), 1'b0};
        tbl[16] = '{1'b1, 1'b0, 8'h99, 0, 0, 1, 8'h00, 8'h00, 8'd8, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 8'h00, 0, 1, 0, 8'h00, 8'h01, 8'd7, 1'b0, 1'b0};

        reset_n    = 1'b0;
        btn_enq_in = 1'b0;
        btn_deq_in = 1'b0;
        sw_data_in = 8'h00;
        repeat (3) @(negedge clk_10KHz);
        check("rst_enqueue", int'(q_enqueue_out), 0);
        check("rst_dequeue", int'(q_dequeue_out), 0);
        check("rst_q_data", int'(q_data_out), 0);
        check("rst_disp_data", int'(disp_data_out), 0);
        check("rst_valid_err", int'({deq_valid_out, err_out}), 0);
        check("rst_full_empty", int'({full_out, empty_out}), 1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_10KHz);

        // Reset in the middle of an enqueue command
        sw_data_in = 8'h3C;
        btn_enq_in = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk_10KHz);
            if (q_enqueue_out) found = 1'b1;
        end
        check("t1_enq_reached", int'(found), 1);
        reset_n = 1'b0;
        #1;
        check("t1_enq_drop", int'(q_enqueue_out), 0);
        check("t1_q_data_clr", int'(q_data_out), 0);
        btn_enq_in = 1'b0;
        repeat (4) @(negedge clk_10KHz);
        reset_n = 1'b1;
        s_enq = enq_seen;
        repeat (20) @(negedge clk_10KHz);
        check("t1_no_retry", enq_seen - s_enq, 0);
        check("t1_len", int'(disp_len_out), 0);

        for (int i = 0; i < 18; i++) apply_op(i, tbl[i]);

        // Bouncing enqueue button, then a clean hold: one command only
        s_enq = enq_seen; s_err = err_seen;
        @(negedge clk_10KHz);
        sw_data_in = 8'h77;
        for (int b = 0; b < 4; b++) begin
            btn_enq_in = (b % 2 == 0);
            repeat (2) @(negedge clk_10KHz);
        end
        btn_enq_in = 1'b1;
        repeat (12) @(negedge clk_10KHz);
        btn_enq_in = 1'b0;
        repeat (12) @(negedge clk_10KHz);
        check("t6_bounce_enq_cnt", enq_seen - s_enq, 1);
        check("t6_bounce_err_cnt", err_seen - s_err, 0);
        check("t6_bounce_q_data", int'(enq_data_last), 8'h77);
        check("t6_bounce_len", int'(disp_len_out), 8);
        check("t6_bounce_full", int'(full_out), 1);

        rec = '{1'b0, 1'b1, 8'h00, 0, 1, 0, 8'h00, 8'h02, 8'd7, 1'b0, 1'b0};
        apply_op(18, rec);

        // Dequeue press lands two cycles after the enqueue request (during ENQ_WAIT)
        s_enq = enq_seen; s_deq = deq_seen; s_err = err_seen;
        @(negedge clk_10KHz);
        sw_data_in = 8'h5A;
        btn_enq_in = 1'b1;
        repeat (2) @(negedge clk_10KHz);
        btn_deq_in = 1'b1;
        repeat (12) @(negedge clk_10KHz);
        btn_enq_in = 1'b0;
        btn_deq_in = 1'b0;
        repeat (12) @(negedge clk_10KHz);
        check("t6_busy_enq_cnt", enq_seen - s_enq, 1);
        check("t6_busy_deq_cnt", deq_seen - s_deq, 0);
        check("t6_busy_err_cnt", err_seen - s_err, 1);
        check("t6_busy_q_data", int'(enq_data_last), 8'h5A);
        check("t6_busy_len", int'(disp_len_out), 8);

        check("inv_no_overlap", overlap_viol, 0);
        check("inv_single_cycle", consec_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
